// File: rtl/field_renderer.sv
// field_renderer: two-stage playfield pixel renderer for the VGA path.
//   Tracks raster position with counters, snapshots the field at start of
//   frame, maps each pixel to a cell code and then a palette colour, and
//   overlays optional grid lines and a line-clear flash sequence.
// Ports:
//   i_clock, i_reset      pixel clock, synchronous active-high reset
//   i_pix_valid, i_sof    pixel strobe and first-pixel-of-frame marker
//   i_field               ROWS*COLS cell codes, cell i at [i*CODE_W +: CODE_W]
//   i_palette             BGR per code, code k at [k*24 +: 24]
//   i_grid_bgr            grid-line colour
//   i_side_bgr            colour right of the field (score panel)
//   i_clear_req           one-cycle flash start request
//   i_clear_rows          rows to flash, bit r = row r
//   o_bgr_out, o_out_valid  rendered pixel, valid two cycles after input
//   o_clear_busy          flash sequencer not idle
//   o_clear_done          one-cycle pulse at sequence end
module field_renderer #(
  parameter int COLS         = 20,
  parameter int ROWS         = 20,
  parameter int CELL_PX      = 24,
  parameter int H_ACTIVE     = 640,
  parameter int CODE_W       = 3,
  parameter int GRID         = 0,
  parameter int FLASH_FRAMES = 32,
  parameter int FLASH_TOGGLE = 8
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_pix_valid,
  input  logic                          i_sof,
  input  logic [ROWS*COLS*CODE_W-1:0]   i_field,
  input  logic [(2**CODE_W)*24-1:0]     i_palette,
  input  logic [23:0]                   i_grid_bgr,
  input  logic [23:0]                   i_side_bgr,
  input  logic                          i_clear_req,
  input  logic [ROWS-1:0]               i_clear_rows,
  output logic [23:0]                   o_bgr_out,
  output logic                          o_out_valid,
  output logic                          o_clear_busy,
  output logic                          o_clear_done
);
  localparam int FIELD_W = COLS * CELL_PX;
  localparam int FIELD_H = ROWS * CELL_PX;
  localparam int XW  = $clog2(H_ACTIVE);
  localparam int YW  = $clog2(FIELD_H + 1);
  localparam int SW  = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
  localparam int CW  = $clog2(H_ACTIVE / CELL_PX + 2);
  localparam int RW  = $clog2(ROWS + 1);
  localparam int RIW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int IW  = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;
  localparam int FCW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam int TCW = (FLASH_TOGGLE > 1) ? $clog2(FLASH_TOGGLE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_FLASH, S_DONE} state_t;

  // Counters hold the position of the next expected pixel; a valid sof
  // overrides them so the sof pixel itself is (0,0).
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [SW-1:0] r_sx, r_sy;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;

  logic          w_start;
  logic [XW-1:0] w_x;
  logic [YW-1:0] w_y;
  logic [SW-1:0] w_sx, w_sy;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic          w_in_field;

  assign w_start = i_pix_valid && i_sof;
  assign w_x   = w_start ? '0 : r_x;
  assign w_y   = w_start ? '0 : r_y;
  assign w_sx  = w_start ? '0 : r_sx;
  assign w_sy  = w_start ? '0 : r_sy;
  assign w_col = w_start ? '0 : r_col;
  assign w_row = w_start ? '0 : r_row;
  assign w_in_field = (w_x < XW'(FIELD_W)) && (w_y < YW'(FIELD_H));

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_x <= '0; r_y <= '0; r_sx <= '0; r_sy <= '0; r_col <= '0; r_row <= '0;
    end else if (i_pix_valid) begin
      if (w_x == XW'(H_ACTIVE - 1)) begin
        r_x <= '0; r_sx <= '0; r_col <= '0;
        // y saturates once below the field so the counters stay bounded
        // through the blank rows of a tall frame.
        if (w_y < YW'(FIELD_H)) begin
          r_y <= w_y + YW'(1);
          if (w_sy == SW'(CELL_PX - 1)) begin
            r_sy <= '0; r_row <= w_row + RW'(1);
          end else begin
            r_sy <= w_sy + SW'(1); r_row <= w_row;
          end
        end else begin
          r_y <= w_y; r_sy <= w_sy; r_row <= w_row;
        end
      end else begin
        r_x <= w_x + XW'(1);
        if (w_sx == SW'(CELL_PX - 1)) begin
          r_sx <= '0; r_col <= w_col + CW'(1);
        end else begin
          r_sx <= w_sx + SW'(1); r_col <= w_col;
        end
        r_y <= w_y; r_sy <= w_sy; r_row <= w_row;
      end
    end
  end

  // Per-frame snapshot; loaded at the sof edge so stage 2 of the sof pixel
  // already reads the new frame's contents.
  logic [ROWS*COLS*CODE_W-1:0] r_field_q;
  always_ff @(posedge i_clock) begin
    if (i_reset)      r_field_q <= '0;
    else if (w_start) r_field_q <= i_field;
  end

  // Flash sequencer
  state_t         r_state;
  logic [ROWS-1:0] r_mask;
  logic [FCW-1:0] r_fcnt;
  logic [TCW-1:0] r_tcnt;
  logic           r_phase;
  logic           r_busy, r_done;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE; r_mask <= '0; r_fcnt <= '0; r_tcnt <= '0;
      r_phase <= 1'b0; r_busy <= 1'b0; r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (i_clear_req) begin
          r_mask <= i_clear_rows; r_state <= S_ARMED; r_busy <= 1'b1;
        end
        S_ARMED: if (w_start) begin
          r_fcnt <= '0; r_tcnt <= '0; r_phase <= 1'b1; r_state <= S_FLASH;
        end
        S_FLASH: if (w_start) begin
          if (r_fcnt == FCW'(FLASH_FRAMES - 1)) begin
            r_state <= S_DONE; r_done <= 1'b1;
          end else begin
            r_fcnt <= r_fcnt + FCW'(1);
            // phase = (frame_cnt / FLASH_TOGGLE) even, tracked incrementally
            if (r_tcnt == TCW'(FLASH_TOGGLE - 1)) begin
              r_tcnt <= '0; r_phase <= ~r_phase;
            end else begin
              r_tcnt <= r_tcnt + TCW'(1);
            end
          end
        end
        S_DONE: begin
          r_mask <= '0; r_state <= S_IDLE; r_busy <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Stage 1: region flags, cell index, side colour
  logic [2:1]      r_vld_pipe;
  logic            r1_side, r1_below, r1_grid;
  logic [IW-1:0]   r1_idx;
  logic [RIW-1:0]  r1_row;
  logic [23:0]     r1_side_bgr;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r1_side <= 1'b0; r1_below <= 1'b0; r1_grid <= 1'b0;
      r1_idx <= '0; r1_row <= '0; r1_side_bgr <= '0;
    end else if (i_pix_valid) begin
      r1_side     <= w_x >= XW'(FIELD_W);
      r1_below    <= w_y >= YW'(FIELD_H);
      r1_grid     <= (GRID != 0) && (w_sx == '0 || w_sy == '0);
      r1_side_bgr <= i_side_bgr;
      r1_idx      <= w_in_field ? IW'(32'(w_row) * COLS + 32'(w_col)) : '0;
      r1_row      <= w_in_field ? RIW'(w_row) : '0;
    end
  end

  // Stage 2: cell lookup, palette and overlay priority
  logic [CODE_W-1:0] w_code;
  logic [23:0]       w_pal;
  assign w_code = CODE_W'(r_field_q >> (32'(r1_idx) * CODE_W));
  assign w_pal  = 24'(i_palette >> (32'(w_code) * 24));

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_vld_pipe <= '0;
      o_bgr_out  <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[1], i_pix_valid};
      if (r_vld_pipe[1]) begin
        if (r1_side)        o_bgr_out <= r1_side_bgr;
        else if (r1_below)  o_bgr_out <= 24'h000000;
        else if (r1_grid)   o_bgr_out <= i_grid_bgr;
        else if (r_state == S_FLASH && r_phase && r_mask[r1_row] && w_code != '0)
                            o_bgr_out <= 24'hFFFFFF;
        else                o_bgr_out <= w_pal;
      end
    end
  end

  assign o_out_valid  = r_vld_pipe[2];
  assign o_clear_busy = r_busy;
  assign o_clear_done = r_done;
endmodule

// File: tb/tb_field_renderer.sv
module tb_field_renderer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, pv, sof, creq;
  logic [19:0]  crows;
  logic [1199:0] field;
  logic [95:0]  field2;
  logic [191:0] pal;
  logic [23:0]  grid, side;
  logic [23:0]  bgr0, bgr1, bgr2;
  logic         ov0, ov1, ov2, busy0, busy1, busy2, done0, done1, done2;

  int checks = 0, errors = 0, pos = 0, done2_cnt = 0;

  // dut0: default geometry, no grid
  field_renderer #(.GRID(0), .FLASH_FRAMES(4), .FLASH_TOGGLE(2)) dut0 (
    .i_clock(clk), .i_reset(rst), .i_pix_valid(pv), .i_sof(sof), .i_field(field),
    .i_palette(pal), .i_grid_bgr(grid), .i_side_bgr(side), .i_clear_req(creq),
    .i_clear_rows(crows), .o_bgr_out(bgr0), .o_out_valid(ov0),
    .o_clear_busy(busy0), .o_clear_done(done0));
  // dut1: default geometry with grid lines
  field_renderer #(.GRID(1), .FLASH_FRAMES(4), .FLASH_TOGGLE(2)) dut1 (
    .i_clock(clk), .i_reset(rst), .i_pix_valid(pv), .i_sof(sof), .i_field(field),
    .i_palette(pal), .i_grid_bgr(grid), .i_side_bgr(side), .i_clear_req(creq),
    .i_clear_rows(crows), .o_bgr_out(bgr1), .o_out_valid(ov1),
    .o_clear_busy(busy1), .o_clear_done(done1));
  // dut2: small geometry so flash frames are short
  field_renderer #(.COLS(4), .ROWS(8), .CELL_PX(2), .H_ACTIVE(10), .GRID(0),
                   .FLASH_FRAMES(4), .FLASH_TOGGLE(2)) dut2 (
    .i_clock(clk), .i_reset(rst), .i_pix_valid(pv), .i_sof(sof), .i_field(field2),
    .i_palette(pal), .i_grid_bgr(grid), .i_side_bgr(side), .i_clear_req(creq),
    .i_clear_rows(crows[7:0]), .o_bgr_out(bgr2), .o_out_valid(ov2),
    .o_clear_busy(busy2), .o_clear_done(done2));

  always @(posedge clk) if (done2) done2_cnt <= done2_cnt + 1;

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic pix(input logic s);
    pv = 1'b1; sof = s;
    @(posedge clk); #1;
    pv = 1'b0; sof = 1'b0;
    pos = s ? 1 : pos + 1;
  endtask

  task automatic skip_to(input int x, input int y, input int h);
    int n;
    n = y * h + x - pos;
    for (int i = 0; i < n; i++) pix(1'b0);
  endtask

  // drive pixel (x,y) then one gap cycle so its result is on the outputs
  task automatic probe(input int x, input int y, input int h);
    skip_to(x, y, h);
    pix(1'b0);
    idle();
  endtask

  task automatic setc(input int r, input int c, input logic [2:0] code);
    field[(r * 20 + c) * 3 +: 3] = code;
  endtask

  task automatic setc2(input int r, input int c, input logic [2:0] code);
    field2[(r * 4 + c) * 3 +: 3] = code;
  endtask

  initial begin
    rst = 1'b1; pv = 1'b0; sof = 1'b0; creq = 1'b0; crows = '0;
    field = '0; field2 = '0; grid = 24'h404040; side = 24'h123456;
    for (int k = 0; k < 8; k++) pal[k * 24 +: 24] = 24'(k * 32'h111111);
    pal[0 +: 24]  = 24'h000000;
    pal[24 +: 24] = 24'h00AA00;
    pal[48 +: 24] = 24'h0000CC;
    pal[72 +: 24] = 24'h333333;
    setc(2, 3, 3'd1); setc(1, 1, 3'd2); setc(1, 19, 3'd3); setc(2, 0, 3'd2);
    setc2(5, 1, 3'd1); setc2(6, 1, 3'd2);

    idle(); idle();
    chk("rst_bgr", bgr0, 24'h0);
    chk("rst_valid", {23'b0, ov0}, 24'h0);
    chk("rst_busy", {23'b0, busy0}, 24'h0);
    chk("rst_done", {23'b0, done0}, 24'h0);
    chk("rst_bgr2", bgr2, 24'h0);
    rst = 1'b0;

    // Frame A
    pix(1'b1);
    probe(24, 24, 640);  chk("c11_d0", bgr0, 24'h0000CC); chk("grid_24_24", bgr1, 24'h404040);
    probe(24, 30, 640);  chk("c11_b", bgr0, 24'h0000CC);  chk("grid_24_30", bgr1, 24'h404040);
    probe(25, 30, 640);  chk("nogrid_25_30", bgr1, 24'h0000CC);
    probe(479, 40, 640); chk("lastcol_d0", bgr0, 24'h333333); chk("lastcol_d1", bgr1, 24'h333333);
    probe(480, 40, 640); chk("side_480", bgr0, 24'h123456);
    skip_to(500, 40, 640); pix(1'b0);
    side = 24'h654321;  // must not affect a pixel already accepted
    idle();
    chk("side_500_d0", bgr0, 24'h123456); chk("side_500_d1", bgr1, 24'h123456);
    probe(504, 40, 640); chk("side_over_grid", bgr1, 24'h654321);
    probe(639, 47, 640); chk("side_639", bgr0, 24'h654321);
    probe(0, 48, 640);   chk("wrap_row2", bgr0, 24'h0000CC); chk("wrap_grid", bgr1, 24'h404040);
    probe(72, 50, 640);  chk("cell23_72", bgr0, 24'h00AA00); chk("grid_72", bgr1, 24'h404040);
    probe(80, 50, 640);  chk("cell23_80", bgr0, 24'h00AA00); chk("cell23_80_d1", bgr1, 24'h00AA00);
    chk("ov_hi", {23'b0, ov0}, 24'h1);
    idle();
    chk("ov_lo", {23'b0, ov0}, 24'h0);
    chk("hold", bgr0, 24'h00AA00);
    setc(2, 3, 3'd2); setc(0, 0, 3'd1);  // mid-frame change
    probe(95, 71, 640);  chk("snap_old", bgr0, 24'h00AA00);
    probe(96, 71, 640);  chk("empty_nb", bgr0, 24'h000000);

    // Frame B: new snapshot visible from the sof pixel on
    pix(1'b1); idle();
    chk("sof_newcode", bgr0, 24'h00AA00); chk("sof_grid", bgr1, 24'h404040);
    probe(5, 5, 640);    chk("newcode_5_5", bgr0, 24'h00AA00);

    // Flash sequence on dut2 (row 5 masked)
    crows = 20'h20; creq = 1'b1; idle(); creq = 1'b0;
    chk("busy_armed", {23'b0, busy2}, 24'h1);
    chk("done_armed", {23'b0, done2}, 24'h0);
    crows = 20'h40; creq = 1'b1; idle(); creq = 1'b0;  // ignored
    chk("busy_armed2", {23'b0, busy2}, 24'h1);

    pix(1'b1);
    probe(2, 10, 10);  chk("f0_white", bgr2, 24'hFFFFFF);
    probe(2, 12, 10);  chk("f0_row6", bgr2, 24'h0000CC);
    probe(8, 13, 10);  chk("f0_side", bgr2, 24'h654321);
    probe(2, 16, 10);  chk("f0_below", bgr2, 24'h000000);
    pix(1'b1);
    probe(3, 11, 10);  chk("f1_white", bgr2, 24'hFFFFFF);
    pix(1'b1);
    probe(2, 10, 10);  chk("f2_pal", bgr2, 24'h00AA00);
    pix(1'b1);
    probe(2, 10, 10);  chk("f3_pal", bgr2, 24'h00AA00);
    chk("f3_nodone", 24'(done2_cnt), 24'h0);
    chk("f3_busy", {23'b0, busy2}, 24'h1);
    pix(1'b1);
    chk("done_pulse", {23'b0, done2}, 24'h1);
    chk("done_busy", {23'b0, busy2}, 24'h1);
    idle();
    chk("done_end", {23'b0, done2}, 24'h0);
    chk("idle_busy", {23'b0, busy2}, 24'h0);
    probe(2, 10, 10);  chk("after_pal", bgr2, 24'h00AA00);
    chk("done_once", 24'(done2_cnt), 24'h1);

    // clear_req together with sof: that sof does not start the flash
    crows = 20'h20; creq = 1'b1; pix(1'b1); creq = 1'b0;
    chk("sim_busy", {23'b0, busy2}, 24'h1);
    probe(2, 10, 10);  chk("sim_noflash", bgr2, 24'h00AA00);
    pix(1'b1);
    probe(2, 10, 10);  chk("sim_flash", bgr2, 24'hFFFFFF);
    rst = 1'b1; idle(); rst = 1'b0;
    chk("rst_fl_busy", {23'b0, busy2}, 24'h0);
    chk("rst_fl_done", {23'b0, done2}, 24'h0);
    chk("rst_fl_bgr", bgr2, 24'h0);
    chk("rst_fl_ov", {23'b0, ov2}, 24'h0);
    idle(); idle(); idle(); idle();
    chk("rst_no_done", 24'(done2_cnt), 24'h1);
    chk("rst_idle", {23'b0, busy2}, 24'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/field_renderer.md
# field_renderer

Pipelined, parametrised playfield pixel renderer for the Tetris VGA path. It sits between the VGA raster timing and the frame output and consumes a raster pixel stream. It tracks the pixel position with internal counters rather than dividers, and maps each position to a multi-bit cell code and then to a colour through a palette. Over the plain on/off field display it adds a per-frame field snapshot (no tearing), optional cell grid lines, and a line-clear flash sequencer with a completion handshake.

## Interface
- COLS, 20, playfield width in cells
- ROWS, 20, playfield height in cells
- CELL_PX, 24, cell edge in pixels (square cells)
- H_ACTIVE, 640, active pixels per line
- CODE_W, 3, bits per cell code; code 0 = empty
- GRID, 0, 1 = draw cell-edge pixels in grid colour
- FLASH_FRAMES, 32, frames in a flash sequence (>=1)
- FLASH_TOGGLE, 8, frames per flash phase (>=1)

Ports:
- clock  in  1  pixel clock
- reset  in  1  synchronous, active-high
- pix_valid  in  1  active pixel present this cycle
- sof  in  1  first pixel of frame; qualified by pix_valid
- field  in  ROWS*COLS*CODE_W  cell codes; cell i = row*COLS+col at [i*CODE_W +: CODE_W]
- palette  in  (2**CODE_W)*24  BGR per code; code k at [k*24 +: 24]
- grid_bgr  in  24  grid-line colour
- side_bgr  in  24  colour for pixels right of the field (score panel)
- clear_req  in  1  one-cycle request to start a flash
- clear_rows  in  ROWS  rows to flash; bit r = row r
- bgr_out  out  24  rendered pixel
- out_valid  out  1  bgr_out valid
- clear_busy  out  1  flash sequencer not IDLE
- clear_done  out  1  one-cycle pulse at sequence end

## Operation
- Position: on pix_valid&&sof, x=0 and y=0. Each other valid pixel increments x. When x==H_ACTIVE-1, x wraps to 0 and y increments. Sub-cell counters (0..CELL_PX-1) and cell col/row counters advance with x/y; no division or modulo is used.
- Snapshot: field is copied into field_q on pix_valid&&sof. All of that frame, including the sof pixel, renders from field_q. sof without pix_valid is ignored.
- Region priority per pixel:
  1. x >= COLS*CELL_PX → side_bgr, sampled in the pixel's input cycle.
  2. y >= ROWS*CELL_PX → 24'h000000.
  3. GRID=1 and sub-cell x or y == 0 → grid_bgr.
  4. Flash on, phase on, clear_mask[row] set and code != 0 → 24'hFFFFFF.
  5. Otherwise palette[code].
- Flash FSM states:
  - IDLE: on clear_req, latch clear_rows into clear_mask and go to ARMED.
  - ARMED: on the next pix_valid&&sof, zero frame_cnt and go to FLASH.
  - FLASH: each subsequent pix_valid&&sof increments frame_cnt. Phase is on when (frame_cnt/FLASH_TOGGLE) is even, so the first frame is on. When frame_cnt reaches FLASH_FRAMES-1 and a sof arrives, go to DONE.
  - DONE: assert clear_done for 1 cycle and clear clear_mask, then go to IDLE.
- clear_req outside IDLE is ignored; the mask is unchanged.
- A zero mask still runs the full sequence.
- clear_busy = (state != IDLE).

## Timing
- Latency is 2 cycles: a pixel presented in cycle n appears on bgr_out/out_valid in cycle n+2. Stage 1 registers cell index, sub-cell flags, region and side_bgr. Stage 2 registers the lookup and palette result.
- out_valid is pix_valid delayed 2 cycles. No stalls; a new pixel may arrive every cycle.
- bgr_out holds its last value while out_valid is low.
- Reset values:
  - bgr_out=0, out_valid=0, clear_busy=0, clear_done=0
  - FSM=IDLE, clear_mask=0, field_q=0, counters=0
  - pipeline valid bits cleared
- Reset mid-flash returns to IDLE with no clear_done pulse.
- Sequence duration: clear_done fires in the cycle after the sof that ends frame FLASH_FRAMES-1 of FLASH.
- Simultaneous clear_req and sof in IDLE: the mask latches and the FSM enters ARMED. That sof does not start FLASH; the next sof does.
- A field change mid-frame is invisible until the next sof.

## Test plan
- Defaults, field cell (row 2, col 3) = code 1, palette[1]=24'h00AA00: pixel x=72..95, y=48..71 → 24'h00AA00 two cycles after input; a neighbouring pixel with code 0 and palette[0]=0 → 24'h000000.
- x=500 with side_bgr=24'h123456 → 24'h123456; x=479 (last field column) → field colour; x wrap at 639 increments the row counter.
- GRID=1, grid_bgr=24'h404040: pixel (24,30) → 24'h404040; pixel (25,30) → cell colour.
- Change field mid-frame → output unchanged until the next sof, then shows the new code.
- FLASH_FRAMES=4, FLASH_TOGGLE=2, clear_rows bit 5 set, occupied cell in row 5:
  - frames 0-1 → 24'hFFFFFF; frames 2-3 → palette colour
  - clear_done pulses once after the 4th FLASH sof
  - clear_busy high from the cycle after clear_req through DONE
- Assert reset during FLASH → clear_busy=0 next cycle, no clear_done; a second clear_req issued during ARMED is ignored.
